// File: rtl/fpu_pkg.sv
// Shared types, constants and helpers for the single-precision FPU sign-injection path.
package fpu_pkg;

  localparam int FP_W = 32;
  localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

  typedef enum logic [1:0] {
    SGNJ     = 2'b00,
    SGNJN    = 2'b01,
    SGNJX    = 2'b10,
    SGNJ_ILL = 2'b11
  } sgnj_op_t;

  // Any NaN, quiet or signalling: all-ones exponent with a non-zero mantissa.
  function automatic logic is_nan(input logic [FP_W-1:0] v);
    return (v[30:23] == EXP_ALL_ONES) && (|v[22:0]);
  endfunction

endpackage

// File: rtl/fpu_sgnj_stage_core.sv
// Combinational fsgnj/fsgnjn/fsgnjx datapath: picks the result sign and flags NaN inputs.
module fpu_sgnj_stage_core
  import fpu_pkg::*;
(
  input  logic [1:0]      op_i,
  input  logic [FP_W-1:0] x1_i,
  input  logic [FP_W-1:0] x2_i,
  output logic [FP_W-1:0] y_o,
  output logic            exc_o
);

  sgnj_op_t op_s;
  logic     nan_s;

  assign op_s  = sgnj_op_t'(op_i);
  assign nan_s = is_nan(x1_i) || is_nan(x2_i);

  // Sign selection; the illegal encoding passes x1 through and always flags.
  always_comb begin
    y_o   = x1_i;
    exc_o = nan_s;
    case (op_s)
      SGNJ:     y_o = {x2_i[31], x1_i[30:0]};
      SGNJN:    y_o = {~x2_i[31], x1_i[30:0]};
      SGNJX:    y_o = {x1_i[31] ^ x2_i[31], x1_i[30:0]};
      SGNJ_ILL: begin
        y_o   = x1_i;
        exc_o = 1'b1;
      end
      default: begin
        y_o   = x1_i;
        exc_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/fpu_sgnj_stage.sv
// Two-stage valid/ready pipeline around the sign-injection datapath.
// Optional FPU_SGNJ_STATS_EN adds stat_ops/stat_exc output-transfer counters.
module fpu_sgnj_stage
  import fpu_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [FP_W-1:0]  in_x1,
  input  logic [FP_W-1:0]  in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  out_y,
  output logic             out_exception,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
`ifdef FPU_SGNJ_STATS_EN
  ,
  output logic [31:0]      stat_ops,
  output logic [31:0]      stat_exc
`endif
);

  logic             s1_valid_q, s1_valid_d;
  logic [1:0]       s1_op_q, s1_op_d;
  logic [FP_W-1:0]  s1_x1_q, s1_x1_d;
  logic [FP_W-1:0]  s1_x2_q, s1_x2_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic             s2_valid_q, s2_valid_d;
  logic [FP_W-1:0]  s2_y_q, s2_y_d;
  logic             s2_exc_q, s2_exc_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  logic             s2_load_s;
  logic             s1_advance_s;
  logic             in_fire_s;
  logic [FP_W-1:0]  core_y_s;
  logic             core_exc_s;

  fpu_sgnj_stage_core u_core (
    .op_i  (s1_op_q),
    .x1_i  (s1_x1_q),
    .x2_i  (s1_x2_q),
    .y_o   (core_y_s),
    .exc_o (core_exc_s)
  );

  assign s2_load_s    = !s2_valid_q || out_ready;
  assign s1_advance_s = s1_valid_q && s2_load_s;
  // Combinational from out_ready so a full pipe can drain and refill in one cycle.
  assign in_ready     = !s1_valid_q || s1_advance_s;
  assign in_fire_s    = in_valid && in_ready;

  // S1 next state: capture on input transfer, empty when it advances without refill.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_x1_d    = s1_x1_q;
    s1_x2_d    = s1_x2_q;
    s1_tag_d   = s1_tag_q;
    if (in_fire_s) begin
      s1_valid_d = 1'b1;
      s1_op_d    = in_op;
      s1_x1_d    = in_x1;
      s1_x2_d    = in_x2;
      s1_tag_d   = in_tag;
    end else if (s1_advance_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // S2 next state: result data only changes when a real entry moves in, keeping out_* stable.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_y_d     = s2_y_q;
    s2_exc_d   = s2_exc_q;
    s2_tag_d   = s2_tag_q;
    if (s2_load_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_y_d   = core_y_s;
        s2_exc_d = core_exc_s;
        s2_tag_d = s1_tag_q;
      end else begin
        s2_y_d   = s2_y_q;
        s2_exc_d = s2_exc_q;
        s2_tag_d = s2_tag_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // S1 registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= 2'b00;
      s1_x1_q    <= {FP_W{1'b0}};
      s1_x2_q    <= {FP_W{1'b0}};
      s1_tag_q   <= {TAG_W{1'b0}};
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_x1_q    <= s1_x1_d;
      s1_x2_q    <= s1_x2_d;
      s1_tag_q   <= s1_tag_d;
    end
  end

  // S2 registers, which drive the outputs directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_y_q     <= {FP_W{1'b0}};
      s2_exc_q   <= 1'b0;
      s2_tag_q   <= {TAG_W{1'b0}};
    end else begin
      s2_valid_q <= s2_valid_d;
      s2_y_q     <= s2_y_d;
      s2_exc_q   <= s2_exc_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign out_valid     = s2_valid_q;
  assign out_y         = s2_y_q;
  assign out_exception = s2_exc_q;
  assign out_tag       = s2_tag_q;
  assign busy          = s1_valid_q || s2_valid_q;

`ifdef FPU_SGNJ_STATS_EN
  logic [31:0] stat_ops_q, stat_ops_d;
  logic [31:0] stat_exc_q, stat_exc_d;

  // Counters advance on output transfers and wrap naturally.
  always_comb begin
    stat_ops_d = stat_ops_q;
    stat_exc_d = stat_exc_q;
    if (s2_valid_q && out_ready) begin
      stat_ops_d = stat_ops_q + 32'd1;
      stat_exc_d = s2_exc_q ? (stat_exc_q + 32'd1) : stat_exc_q;
    end else begin
      stat_ops_d = stat_ops_q;
      stat_exc_d = stat_exc_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops_q <= 32'd0;
      stat_exc_q <= 32'd0;
    end else begin
      stat_ops_q <= stat_ops_d;
      stat_exc_q <= stat_exc_d;
    end
  end

  assign stat_ops = stat_ops_q;
  assign stat_exc = stat_exc_q;
`endif

endmodule
